input_mapper: RTL and testbench

//  Parametrised successor to the fixed per-core keyboard/joystick decode in the emu top level.
//  - Merges PS/2 key events and hps_io joystick words into registered per-player control words.
//  - Player count, button count and service key count are parameters.
//  - The key-to-control map is written at runtime through a config port instead of hard-coded scancodes.
//  - Coin inputs are pulse-stretched.
//  - Sits in emu between hps_io and Main, in the clk_sys domain.

---
 rtl/input_mapper.sv | 156 +++++++++++++++
 tb/tb_input_mapper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_mapper.sv
// input_mapper
//   Merges PS/2 key events and hps_io joystick words into registered
//   per-player control words. The key-to-control map is loaded at runtime
//   through a small write port. Coin bits are pulse-stretched so short
//   pulses are still seen by the core.
//
//   Optional feature: define AUTOFIRE_EN to build the autofire phase
//   generator and honour af_mask. Without it, af_mask is ignored and
//   buttons pass straight through.
//
// Ports
//   clock     in   clk_sys
//   reset     in   synchronous, active-high
//   ps2_key   in   [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   joystick  in   hps_io words, player p at [p*W +: W]
//   map_wr    in   write one key-map slot
//   map_slot  in   slot index (values >= S are ignored)
//   map_code  in   {extended, scancode}; 9'h000 means unmapped
//   af_mask   in   per-button autofire enable
//   players   out  per-player control word, same bit order as joystick
//   service   out  service key states
//
// Player word: [0] right, [1] left, [2] down, [3] up, [4 +: NB] buttons,
//              [4+NB] start, [5+NB] coin, [6+NB] pause.

module input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 3,
  parameter int NUM_SERVICE = 2,
  parameter int COIN_MIN    = 16,
  parameter int AF_PERIOD   = 4096,
  localparam int W          = NUM_BUTTONS + 7,
  localparam int S          = NUM_PLAYERS * W + NUM_SERVICE,
  localparam int SLOT_W     = $clog2(S)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic [NUM_PLAYERS*W-1:0]           joystick,
  input  logic                               map_wr,
  input  logic [SLOT_W-1:0]                  map_slot,
  input  logic [8:0]                         map_code,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] af_mask,
  output logic [NUM_PLAYERS*W-1:0]           players,
  output logic [NUM_SERVICE-1:0]             service
);

  localparam int PW       = NUM_PLAYERS * W;
  localparam int CW       = $clog2(COIN_MIN + 1);
  localparam int COIN_BIT = 5 + NUM_BUTTONS;

  logic             toggle_q;
  logic             key_event;
  logic [8:0]       key_map [S];
  logic [S-1:0]     key_state;
  logic [PW-1:0]    raw;
  logic [PW-1:0]    players_next;
  logic [NUM_PLAYERS-1:0] coin_prev;
  logic [CW-1:0]    coin_cnt [NUM_PLAYERS];

  // The toggle bit is tracked even during reset so that the first edge
  // after reset does not produce a spurious event.
  always_ff @(posedge clock) begin
    toggle_q <= ps2_key[10];
  end

  assign key_event = ps2_key[10] ^ toggle_q;

  // Key map and key state. The map write is placed after the event update
  // so a write to a slot overrides an event hitting the same slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_state <= '0;
      for (int s = 0; s < S; s++) begin
        key_map[s] <= 9'h000;
      end
    end else begin
      for (int s = 0; s < S; s++) begin
        if (key_event && (key_map[s] != 9'h000) && (key_map[s] == ps2_key[8:0])) begin
          key_state[s] <= ps2_key[9];
        end
        if (map_wr && (map_slot == SLOT_W'(s))) begin
          key_map[s]   <= map_code;
          key_state[s] <= 1'b0;
        end
      end
    end
  end

  assign raw = key_state[PW-1:0] | joystick;

`ifdef AUTOFIRE_EN
  localparam int AFW = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;

  logic [AFW-1:0] af_cnt;
  logic           af_phase;

  // Free-running phase generator; the phase starts high so a freshly
  // pressed autofire button fires immediately after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AFW'(AF_PERIOD - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end
`else
  logic unused_af;
  assign unused_af = (^af_mask) ^ (AF_PERIOD == 0);
`endif

  // Output word before registering: raw bits, with each coin bit held high
  // while its stretch counter is still running.
  always_comb begin
    players_next = raw;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      players_next[p*W + COIN_BIT] = raw[p*W + COIN_BIT] | (coin_cnt[p] != '0);
`ifdef AUTOFIRE_EN
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (af_mask[p*NUM_BUTTONS + b]) begin
          players_next[p*W + 4 + b] = raw[p*W + 4 + b] & af_phase;
        end
      end
`endif
    end
  end

  // Coin stretch counters and output registers. A rising raw coin edge
  // (re)loads the counter; otherwise it counts down and rests at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      coin_prev <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        coin_cnt[p] <= '0;
      end
      players <= '0;
      service <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        coin_prev[p] <= raw[p*W + COIN_BIT];
        if (raw[p*W + COIN_BIT] && !coin_prev[p]) begin
          coin_cnt[p] <= CW'(COIN_MIN - 1);
        end else if (coin_cnt[p] != '0) begin
          coin_cnt[p] <= coin_cnt[p] - 1'b1;
        end
      end
      players <= players_next;
      service <= key_state[PW +: NUM_SERVICE];
    end
  end

endmodule

// File: tb/tb_input_mapper.sv
// tb_input_mapper
//   Directed scenarios followed by a randomized run, all compared every
//   cycle against a behavioural model of the mapper. Coin stretching is
//   modelled as "cycles since the last rising edge" and autofire as
//   "which half-period of the free-running phase we are in".

module tb_input_mapper;

  localparam int NP   = 2;
  localparam int NB   = 3;
  localparam int NS   = 2;
  localparam int CM   = 16;
  localparam int AFP  = 8;
  localparam int W    = NB + 7;
  localparam int S    = NP * W + NS;
  localparam int SW   = $clog2(S);
  localparam int PW   = NP * W;
  localparam int COIN = 5 + NB;

  logic           clock = 1'b0;
  logic           reset;
  logic [10:0]    ps2_key;
  logic [PW-1:0]  joystick;
  logic           map_wr;
  logic [SW-1:0]  map_slot;
  logic [8:0]     map_code;
  logic [NP*NB-1:0] af_mask;
  logic [PW-1:0]  players;
  logic [NS-1:0]  service;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0]     m_map [S];
  logic [S-1:0]   m_state;
  logic           m_tog;
  int             m_rise [NP];
  logic [NP-1:0]  m_prev_coin;
  int             m_cyc = 0;
  int             m_af_n = 0;
  logic [PW-1:0]  exp_players;
  logic [NS-1:0]  exp_service;

  logic [8:0] pool [5] = '{9'h000, 9'h014, 9'h175, 9'h076, 9'h11c};

  always #5 clock = ~clock;

  input_mapper #(
    .NUM_PLAYERS(NP),
    .NUM_BUTTONS(NB),
    .NUM_SERVICE(NS),
    .COIN_MIN   (CM),
    .AF_PERIOD  (AFP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joystick(joystick),
    .map_wr  (map_wr),
    .map_slot(map_slot),
    .map_code(map_code),
    .af_mask (af_mask),
    .players (players),
    .service (service)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Predict the register contents after the coming clock edge from the
  // inputs currently applied and the model's pre-edge state.
  task automatic model_edge();
    logic [PW-1:0] raw;
    logic [S-1:0]  ns;
    int            c;
    raw = m_state[PW-1:0] | joystick;
    ns  = m_state;
    if (reset) begin
      exp_players = '0;
      exp_service = '0;
      for (int p = 0; p < NP; p++) m_rise[p] = -1000000;
      m_prev_coin = '0;
      m_af_n      = 0;
      for (int s = 0; s < S; s++) m_map[s] = 9'h000;
      ns = '0;
    end else begin
      exp_players = raw;
      exp_service = m_state[PW +: NS];
      for (int p = 0; p < NP; p++) begin
        c = p * W + COIN;
        if (m_cyc - m_rise[p] < CM) exp_players[c] = 1'b1;
        if (raw[c] && !m_prev_coin[p]) m_rise[p] = m_cyc;
        m_prev_coin[p] = raw[c];
      end
`ifdef AUTOFIRE_EN
      if (((m_af_n / AFP) % 2) == 1) begin
        for (int p = 0; p < NP; p++)
          for (int b = 0; b < NB; b++)
            if (af_mask[p*NB + b]) exp_players[p*W + 4 + b] = 1'b0;
      end
`endif
      m_af_n++;
      if (ps2_key[10] != m_tog) begin
        for (int s = 0; s < S; s++)
          if (m_map[s] != 9'h000 && m_map[s] == ps2_key[8:0]) ns[s] = ps2_key[9];
      end
      if (map_wr && int'(map_slot) < S) begin
        m_map[map_slot] = map_code;
        ns[map_slot]    = 1'b0;
      end
    end
    m_state = ns;
    m_tog   = ps2_key[10];
    m_cyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("players_model", 32'(players), 32'(exp_players));
    check("service_model", 32'(service), 32'(exp_service));
  endtask

  task automatic write_map(input int slot, input logic [8:0] code);
    map_wr   = 1'b1;
    map_slot = SW'(slot);
    map_code = code;
    step();
    map_wr   = 1'b0;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    step();
    step();
  endtask

  initial begin
    int high;
    int r;
    reset    = 1'b1;
    ps2_key  = '0;
    joystick = '0;
    map_wr   = 1'b0;
    map_slot = '0;
    map_code = '0;
    af_mask  = '0;
    repeat (3) step();
    reset = 1'b0;
    check("reset_players", 32'(players), 32'd0);
    check("reset_service", 32'(service), 32'd0);

    // Map / press / release on P1 up
    write_map(3, 9'h175);
    send_key(1'b1, 9'h175);
    check("up_press", 32'(players[3]), 32'd1);
    send_key(1'b0, 9'h175);
    check("up_release", 32'(players[3]), 32'd0);

    // Same scancode without the extended prefix must not match
    send_key(1'b1, 9'h075);
    check("ext_mismatch", 32'(players), 32'd0);

    // Duplicate mapping to both players' first button
    write_map(4, 9'h014);
    write_map(W + 4, 9'h014);
    send_key(1'b1, 9'h014);
    check("dup_p1_b1", 32'(players[4]), 32'd1);
    check("dup_p2_b1", 32'(players[W + 4]), 32'd1);
    send_key(1'b0, 9'h014);

    // Joystick merge has one cycle of latency
    joystick[W + 5] = 1'b1;
    step();
    check("joy_merge", 32'(players[W + 5]), 32'd1);
    joystick = '0;
    step();

    // Single-cycle coin pulse is stretched to COIN_MIN cycles
    joystick[COIN] = 1'b1;
    step();
    joystick = '0;
    high = int'(players[COIN]);
    for (int i = 0; i < 30; i++) begin
      step();
      high += int'(players[COIN]);
    end
    check("coin_stretch", 32'(high), 32'd16);

    // Retrigger ten cycles after the first pulse
    joystick[COIN] = 1'b1;
    step();
    joystick = '0;
    high = int'(players[COIN]);
    for (int i = 0; i < 9; i++) begin
      step();
      high += int'(players[COIN]);
    end
    joystick[COIN] = 1'b1;
    step();
    high += int'(players[COIN]);
    joystick = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      high += int'(players[COIN]);
    end
    check("coin_retrigger", 32'(high), 32'd26);

    // Service key: two-cycle latency from the event
    write_map(PW, 9'h076);
    ps2_key = {~ps2_key[10], 1'b1, 9'h076};
    step();
    check("service_early", 32'(service[0]), 32'd0);
    step();
    check("service_press", 32'(service[0]), 32'd1);
    send_key(1'b0, 9'h076);

    // Reset while up is held drops it and clears the map
    send_key(1'b1, 9'h175);
    check("up_held", 32'(players[3]), 32'd1);
    reset = 1'b1;
    step();
    check("reset_drop", 32'(players), 32'd0);
    reset = 1'b0;
    step();
    send_key(1'b1, 9'h175);
    check("map_cleared", 32'(players[3]), 32'd0);

    // A map write beats a matching event on the same slot
    write_map(3, 9'h175);
    send_key(1'b1, 9'h175);
    check("rewrite_press", 32'(players[3]), 32'd1);
    map_wr   = 1'b1;
    map_slot = SW'(3);
    map_code = 9'h175;
    ps2_key  = {~ps2_key[10], 1'b1, 9'h175};
    step();
    map_wr = 1'b0;
    step();
    check("write_wins", 32'(players[3]), 32'd0);

    // Autofire on P1 B1
    write_map(4, 9'h014);
    send_key(1'b1, 9'h014);
    af_mask = 6'b000001;
    high = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      high += int'(players[4]);
    end
`ifdef AUTOFIRE_EN
    check("af_masked", 32'(high), 32'd16);
`else
    check("af_masked", 32'(high), 32'd32);
`endif
    af_mask = '0;
    high = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      high += int'(players[4]);
    end
    check("af_unmasked", 32'(high), 32'd16);
    send_key(1'b0, 9'h014);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      map_wr = 1'b0;
      if (r < 10) begin
        map_wr   = 1'b1;
        map_slot = SW'($urandom_range(0, 31));
        map_code = pool[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 1)
          ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)]};
      end else if (r < 45) begin
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)]};
      end
      if (r % 4 == 0) joystick = PW'($urandom & $urandom & $urandom);
      if (r == 50) af_mask = (NP*NB)'($urandom);
      reset = (r == 99);
      step();
    end
    reset  = 1'b0;
    map_wr = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
